// File: rtl/vrf_bank_read_arbiter_pkg.sv
// Shared constants and index helpers for the VRF bank read path.
// Provides the bank/row split of an architectural register index so that
// the read arbiter and the write-back path decode addresses identically.
//   bank_of(idx) : low BANK_W bits, selects the register bank
//   row_of(idx)  : remaining upper bits, selects the row inside that bank
package vrf_bank_read_arbiter_pkg;

  localparam int NUM_REQ   = 4;
  localparam int REQ_W     = 2;
  localparam int NUM_BANK  = 4;
  localparam int BANK_W    = 2;
  localparam int REG_IDX_W = 10;
  localparam int ROW_W     = REG_IDX_W - BANK_W;  // DEPTH_REGBANK

  typedef logic [REG_IDX_W-1:0] reg_idx_t;
  typedef logic [BANK_W-1:0]    bank_t;
  typedef logic [ROW_W-1:0]     row_t;
  typedef logic [REQ_W-1:0]     ptr_t;

  function automatic bank_t bank_of(input reg_idx_t idx);
    return idx[BANK_W-1:0];
  endfunction

  function automatic row_t row_of(input reg_idx_t idx);
    return idx[REG_IDX_W-1:BANK_W];
  endfunction

endpackage

// File: rtl/vrf_bank_read_arbiter_if.sv
// Requester-side read interface of the VRF bank read arbiter.
//   req_valid_i  : per-requester read request
//   req_idx_i    : per-requester register index, slice r = [REG_IDX_W*(r+1)-1 -: REG_IDX_W]
//   req_ready_o  : per-requester grant (request consumed this cycle)
//   resp_valid_o : read data for requester r is on its bank's output this cycle
//   resp_bank_o  : bank whose output requester r must select, slice r = [BANK_W*(r+1)-1 -: BANK_W]
// master = operand collector, slave = arbiter.
interface vrf_bank_read_arbiter_if;
  import vrf_bank_read_arbiter_pkg::*;

  logic [NUM_REQ-1:0]           req_valid_i;
  logic [NUM_REQ*REG_IDX_W-1:0] req_idx_i;
  logic [NUM_REQ-1:0]           req_ready_o;
  logic [NUM_REQ-1:0]           resp_valid_o;
  logic [NUM_REQ*BANK_W-1:0]    resp_bank_o;

  modport master (
    output req_valid_i,
    output req_idx_i,
    input  req_ready_o,
    input  resp_valid_o,
    input  resp_bank_o
  );

  modport slave (
    input  req_valid_i,
    input  req_idx_i,
    output req_ready_o,
    output resp_valid_o,
    output resp_bank_o
  );

endinterface

// File: rtl/vrf_bank_read_arbiter_rr_arbiter_onehot.sv
// Combinational round-robin arbiter with an external pointer.
//   req_i : request vector, one bit per requester
//   ptr_i : highest-priority requester this cycle
//   gnt_o : one-hot grant (all zero when nothing requests)
// The scan starts at ptr_i and wraps modulo N.
module rr_arbiter_onehot #(
  parameter int N     = 4,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o
);

  logic             found;
  logic [PTR_W-1:0] pos;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    pos   = '0;
    for (int i = 0; i < N; i++) begin
      pos = PTR_W'((int'(ptr_i) + i) % N);
      if (!found && req_i[pos]) begin
        gnt_o[pos] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vrf_bank_read_arbiter.sv
// Read arbiter for the banked vector register file.
// Each requester's index is split into bank/row; each bank grants at most one
// requester per cycle with its own round-robin pointer. Winners drive the bank
// read enable/row, and a registered response strobe plus bank select follow one
// cycle later, aligned with the bank SRAM read data.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   rd            : requester interface (slave side)
//   flush_i       : suppress all grants this cycle, kill the next-cycle responses
//   wb_wen_i      : write-back active this cycle
//   wb_idx_i      : write-back register index
//   bank_rsren_o  : per-bank read enable
//   bank_rsidx_o  : per-bank read row, slice b = [ROW_W*(b+1)-1 -: ROW_W]
module vrf_bank_read_arbiter
  import vrf_bank_read_arbiter_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  vrf_bank_read_arbiter_if.slave    rd,
  input  logic                      flush_i,
  input  logic                      wb_wen_i,
  input  logic [REG_IDX_W-1:0]      wb_idx_i,
  output logic [NUM_BANK-1:0]       bank_rsren_o,
  output logic [NUM_BANK*ROW_W-1:0] bank_rsidx_o
);

  reg_idx_t            req_idx  [NUM_REQ];
  bank_t               req_bank [NUM_REQ];
  row_t                req_row  [NUM_REQ];
  logic [NUM_REQ-1:0]  elig     [NUM_BANK];
  logic [NUM_REQ-1:0]  gnt      [NUM_BANK];
  ptr_t                ptr_q    [NUM_BANK];
  logic [NUM_REQ-1:0]  ready;
  logic [NUM_REQ-1:0]  resp_valid_q;
  logic [NUM_REQ*BANK_W-1:0] resp_bank_q;

  bank_t wb_bank;
  row_t  wb_row;

  assign wb_bank = bank_of(wb_idx_i);
  assign wb_row  = row_of(wb_idx_i);

  for (genvar r = 0; r < NUM_REQ; r++) begin : g_req
    assign req_idx[r]  = rd.req_idx_i[REG_IDX_W*(r+1)-1 -: REG_IDX_W];
    assign req_bank[r] = bank_of(req_idx[r]);
    assign req_row[r]  = row_of(req_idx[r]);
    // A requester only ever competes on its own bank, so its grant is read there.
    assign ready[r]    = gnt[req_bank[r]][r];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        resp_valid_q[r]                       <= 1'b0;
        resp_bank_q[BANK_W*(r+1)-1 -: BANK_W] <= '0;
      end else begin
        resp_valid_q[r] <= ready[r] && !flush_i;
        if (ready[r]) begin
          resp_bank_q[BANK_W*(r+1)-1 -: BANK_W] <= req_bank[r];
        end
      end
    end
  end

  for (genvar b = 0; b < NUM_BANK; b++) begin : g_bank
    for (genvar r = 0; r < NUM_REQ; r++) begin : g_elig
      // Reading the row being written this cycle would return stale data,
      // so that requester sits out and retries; its pointer slot is untouched.
      logic hazard;
      assign hazard = wb_wen_i && (wb_bank == bank_t'(b)) && (wb_row == req_row[r]);
      // rst_n gating keeps every grant-side output low while reset is held.
      assign elig[b][r] = rst_n && !flush_i && rd.req_valid_i[r]
                          && (req_bank[r] == bank_t'(b)) && !hazard;
    end

    rr_arbiter_onehot #(
      .N     (NUM_REQ),
      .PTR_W (REQ_W)
    ) u_arb (
      .req_i (elig[b]),
      .ptr_i (ptr_q[b]),
      .gnt_o (gnt[b])
    );

    assign bank_rsren_o[b] = |gnt[b];

    row_t win_row;
    always_comb begin
      win_row = '0;
      for (int r = 0; r < NUM_REQ; r++) begin
        if (gnt[b][r]) win_row = req_row[r];
      end
    end
    assign bank_rsidx_o[ROW_W*(b+1)-1 -: ROW_W] = win_row;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        ptr_q[b] <= '0;
      end else begin
        for (int r = 0; r < NUM_REQ; r++) begin
          if (gnt[b][r]) ptr_q[b] <= REQ_W'((r + 1) % NUM_REQ);
        end
      end
    end
  end

  assign rd.req_ready_o  = ready;
  assign rd.resp_valid_o = resp_valid_q;
  assign rd.resp_bank_o  = resp_bank_q;

endmodule

// File: tb/tb_vrf_bank_read_arbiter.sv
// Directed bench for vrf_bank_read_arbiter with a response scoreboard.
module tb_vrf_bank_read_arbiter;
  import vrf_bank_read_arbiter_pkg::*;

  typedef struct packed {
    logic [3:0] v;
    logic [7:0] b;
  } resp_t;

  logic        clk;
  logic        rst_n;
  logic        flush_i;
  logic        wb_wen_i;
  logic [9:0]  wb_idx_i;
  logic [3:0]  bank_rsren_o;
  logic [31:0] bank_rsidx_o;

  int    errors = 0;
  int    checks = 0;
  resp_t sb[$];

  vrf_bank_read_arbiter_if u_if ();

  vrf_bank_read_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rd           (u_if.slave),
    .flush_i      (flush_i),
    .wb_wen_i     (wb_wen_i),
    .wb_idx_i     (wb_idx_i),
    .bank_rsren_o (bank_rsren_o),
    .bank_rsidx_o (bank_rsidx_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [39:0] pk(input logic [9:0] i0, input logic [9:0] i1,
                                     input logic [9:0] i2, input logic [9:0] i3);
    return {i3, i2, i1, i0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge: drive, sample 1 time unit later, score, then advance one cycle.
  task automatic step(input string tag, input logic [3:0] v, input logic [39:0] idx,
                      input logic fl, input logic wen, input logic [9:0] widx,
                      input logic [3:0] e_ready, input logic [3:0] e_rsren,
                      input logic [31:0] e_rsidx);
    resp_t       e;
    resp_t       n;
    logic [7:0]  mask;
    u_if.req_valid_i = v;
    u_if.req_idx_i   = idx;
    flush_i          = fl;
    wb_wen_i         = wen;
    wb_idx_i         = widx;
    #1;
    chk({tag, " ready"}, 32'(u_if.req_ready_o), 32'(e_ready));
    chk({tag, " rsren"}, 32'(bank_rsren_o), 32'(e_rsren));
    chk({tag, " rsidx"}, bank_rsidx_o, e_rsidx);
    e = '0;
    if (sb.size() > 0) e = sb.pop_front();
    chk({tag, " resp_valid"}, 32'(u_if.resp_valid_o), 32'(e.v));
    if (e.v != 4'b0) begin
      mask = '0;
      for (int r = 0; r < 4; r++) if (e.v[r]) mask[2*r +: 2] = 2'b11;
      chk({tag, " resp_bank"}, 32'(u_if.resp_bank_o & mask), 32'(e.b & mask));
    end
    n   = '0;
    n.v = e_ready & {4{~fl}};
    for (int r = 0; r < 4; r++) if (n.v[r]) n.b[2*r +: 2] = idx[10*r +: 2];
    sb.push_back(n);
    @(posedge clk);
    @(negedge clk);
  endtask

  // Asynchronous reset with current inputs still applied; everything must drop at once.
  task automatic reset_pulse(input string tag);
    rst_n = 1'b0;
    #1;
    chk({tag, " ready"},      32'(u_if.req_ready_o), 32'h0);
    chk({tag, " rsren"},      32'(bank_rsren_o), 32'h0);
    chk({tag, " rsidx"},      bank_rsidx_o, 32'h0);
    chk({tag, " resp_valid"}, 32'(u_if.resp_valid_o), 32'h0);
    chk({tag, " resp_bank"},  32'(u_if.resp_bank_o), 32'h0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    u_if.req_valid_i = 4'b1111;
    u_if.req_idx_i   = pk(10'd0, 10'd1, 10'd2, 10'd3);
    flush_i          = 1'b0;
    wb_wen_i         = 1'b0;
    wb_idx_i         = 10'd0;
    rst_n            = 1'b0;
    @(negedge clk);
    reset_pulse("por");

    // distinct banks: all granted together, row 0 everywhere
    step("dist",  4'b1111, pk(10'd0, 10'd1, 10'd2, 10'd3), 0, 0, 10'd0, 4'b1111, 4'b1111, 32'h0);
    step("idle0", 4'b0000, pk(10'd0, 10'd0, 10'd0, 10'd0), 0, 0, 10'd0, 4'b0000, 4'b0000, 32'h0);
    reset_pulse("rst2");

    // all four on bank 0 row 1, served in round-robin order; the winner drops valid
    step("rr0", 4'b1111, pk(10'd4, 10'd4, 10'd4, 10'd4), 0, 0, 10'd0, 4'b0001, 4'b0001, 32'h1);
    step("rr1", 4'b1110, pk(10'd4, 10'd4, 10'd4, 10'd4), 0, 0, 10'd0, 4'b0010, 4'b0001, 32'h1);
    step("rr2", 4'b1100, pk(10'd4, 10'd4, 10'd4, 10'd4), 0, 0, 10'd0, 4'b0100, 4'b0001, 32'h1);
    step("rr3", 4'b1000, pk(10'd4, 10'd4, 10'd4, 10'd4), 0, 0, 10'd0, 4'b1000, 4'b0001, 32'h1);
    // pointer wrapped to 0: requester 0 beats requester 3
    step("wrap", 4'b1001, pk(10'd4, 10'd0, 10'd0, 10'd4), 0, 0, 10'd0, 4'b0001, 4'b0001, 32'h1);

    // write hazard on idx 9 (bank 1, row 2)
    step("haz",    4'b0010, pk(10'd0, 10'd9, 10'd0, 10'd0), 0, 1, 10'd9,  4'b0000, 4'b0000, 32'h0);
    step("hazrel", 4'b0010, pk(10'd0, 10'd9, 10'd0, 10'd0), 0, 0, 10'd9,  4'b0010, 4'b0010, 32'h200);
    step("hazrow", 4'b0010, pk(10'd0, 10'd9, 10'd0, 10'd0), 0, 1, 10'd13, 4'b0010, 4'b0010, 32'h200);

    // flush: previous response still shown, no grants, nothing next cycle
    step("pref",  4'b0100, pk(10'd0, 10'd0, 10'd2, 10'd0), 0, 0, 10'd0, 4'b0100, 4'b0100, 32'h0);
    step("flush", 4'b1111, pk(10'd0, 10'd1, 10'd2, 10'd3), 1, 0, 10'd0, 4'b0000, 4'b0000, 32'h0);
    step("postf", 4'b0000, pk(10'd0, 10'd0, 10'd0, 10'd0), 0, 0, 10'd0, 4'b0000, 4'b0000, 32'h0);

    // bank0 pointer is 1 (held across flush): requester 1 wins, pointer becomes 2
    step("ptr2", 4'b0011, pk(10'd0, 10'd0, 10'd0, 10'd0), 0, 0, 10'd0, 4'b0010, 4'b0001, 32'h0);

    // reset during contention at ptr0=2 with a response in flight
    u_if.req_valid_i = 4'b1001;
    u_if.req_idx_i   = pk(10'd0, 10'd0, 10'd0, 10'd0);
    reset_pulse("midrst");
    step("post0", 4'b1001, pk(10'd0, 10'd0, 10'd0, 10'd0), 0, 0, 10'd0, 4'b0001, 4'b0001, 32'h0);
    step("post1", 4'b1000, pk(10'd0, 10'd0, 10'd0, 10'd0), 0, 0, 10'd0, 4'b1000, 4'b0001, 32'h0);
    step("drain", 4'b0000, pk(10'd0, 10'd0, 10'd0, 10'd0), 0, 0, 10'd0, 4'b0000, 4'b0000, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vrf_bank_read_arbiter.md
Name: vrf_bank_read_arbiter

Overview:
- Arbitrates read access to the vector register file banks among the operand-collector requesters.
- Maps each requested register index to a bank and row, and grants at most one read per bank per cycle using per-bank round-robin.
- Drives each bank's read index and read enable, and returns a registered response strobe plus bank select one cycle later, aligned with the bank SRAM read data.
- Masks reads that hit the row being written in the same cycle, so stale data is never returned.

Parameters:
- NUM_REQ, 4, number of read requesters (collector operand slots).
- NUM_BANK, 4, number of register banks; power of two.
- BANK_W, 2, log2(NUM_BANK).
- REG_IDX_W, 10, architectural vector register index width.
- ROW_W, 8, bank row index width (REG_IDX_W-BANK_W); equals DEPTH_REGBANK.
- REQ_W, 2, log2(NUM_REQ).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid_i  in  NUM_REQ  read request per requester.
- req_idx_i  in  NUM_REQ*REG_IDX_W  register index per requester; slice r is [REG_IDX_W*(r+1)-1 -: REG_IDX_W].
- req_ready_o  out  NUM_REQ  grant this cycle; the request is consumed.
- flush_i  in  1  drop all grants this cycle and kill in-flight responses.
- wb_wen_i  in  1  write-back active this cycle.
- wb_idx_i  in  REG_IDX_W  write-back register index.
- bank_rsren_o  out  NUM_BANK  per-bank read enable (drives rsren_i).
- bank_rsidx_o  out  NUM_BANK*ROW_W  per-bank read row (drives rsidx_i).
- resp_valid_o  out  NUM_REQ  read data for requester r is on its bank's rs_o this cycle.
- resp_bank_o  out  NUM_REQ*BANK_W  bank whose rs_o requester r must select.

Behaviour:
- Address split: bank = idx[BANK_W-1:0]; row = idx[REG_IDX_W-1:BANK_W].
- Eligibility: requester r is eligible for bank b when:
  - req_valid_i[r] is high, and bank(req_idx r)==b;
  - it is not hazard-masked, i.e. NOT (wb_wen_i && bank(wb_idx_i)==b && row(wb_idx_i)==row(req r));
  - flush_i is low.
- Arbitration (combinational, same cycle):
  - Each bank has a REQ_W-bit pointer ptr_b.
  - The winner is the first eligible r scanning ptr_b, ptr_b+1, ... mod NUM_REQ.
  - A requester targets one bank, so it wins at most once per cycle.
- Grant outputs:
  - req_ready_o[r] = 1 iff r won its bank.
  - bank_rsren_o[b] = 1 iff bank b has a winner.
  - bank_rsidx_o slice b = winner's row when granted, else 0.
- Pointer update (registered): on grant to r at bank b, ptr_b <= (r+1) mod NUM_REQ. No grant leaves the pointer unchanged.
- Handshake rules:
  - A requester holds valid and idx stable until ready.
  - ready may depend combinationally on valid.
  - valid must not depend on ready.
- Response: 1-cycle latency, matching the bank SRAM.
  - resp_valid_o[r] <= req_ready_o[r] && !flush_i.
  - resp_bank_o slice r <= bank(req_idx r) when granted; otherwise it holds its value.
- Flush: when flush_i=1, no grants issue this cycle, all pointers hold, and resp_valid_o is cleared the next cycle. Responses already visible this cycle are still presented.
- Write hazard masking:
  - A masked requester is retried on later cycles; its pointer position is unaffected.
  - A write to a different row of the same bank does not block the read.
- Reset:
  - Asynchronous assertion forces all pointers and resp_valid_o/resp_bank_o to 0.
  - While rst_n=0, req_ready_o, bank_rsren_o and bank_rsidx_o are forced 0 regardless of inputs.
  - Reset mid-operation discards in-flight responses.
- Boundaries:
  - All NUM_REQ requesters on one bank are served in NUM_REQ cycles, in round-robin order.
  - All requesters on distinct banks are granted in the same cycle.
  - The pointer wraps from NUM_REQ-1 to 0.

Decomposition:
- Shared package/defines holds:
  - NUM_BANK, BANK_W, ROW_W (= DEPTH_REGBANK), REG_IDX_W;
  - the bank/row extraction macros, also used by the write-back path.
- One sub-module: rr_arbiter_onehot (NUM_REQ-bit request vector plus pointer in, one-hot grant out), instantiated NUM_BANK times.

Test Plan:
- Requesters 0..3 with idx 0,1,2,3 (distinct banks) -> all ready in cycle 0; bank_rsidx all 0; resp_valid=4'b1111 at cycle 1 with resp_bank 0,1,2,3.
- Requesters 0..3 all idx 4 (bank 0, row 1), held -> ready 0,1,2,3 on successive cycles; rsidx bank0=1 each cycle; ptr0 ends at 0.
- Requester 1 idx 9 plus wb_wen_i=1 with wb_idx 9 -> no grant that cycle; requester 1 granted the cycle after wb_wen drops. wb_idx 13 (same bank, row 3) -> requester 1 granted immediately.
- Grant to requester 2 at cycle n, flush_i=1 at n+1 together with new requests -> resp_valid[2]=1 at n+1, no grants at n+1, resp_valid all 0 at n+2.
- Reset asserted during contention at ptr0=2 -> outputs 0 immediately. After release, requesters 0 and 3 both on bank 0 -> requester 0 wins first.
